// File: rtl/ccd_phase_gen.sv
// ccd_phase_gen: multi-phase CCD clock generator with a shared period, per-phase offsets
// and glitch-free start/stop gating from a level enable.
module ccd_phase_gen #(
  parameter int NPH   = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [CNT_W-1:0]     half_period,
  input  logic [NPH*CNT_W-1:0] phase_off,
  output logic [NPH-1:0]       ph,
  output logic                 sync,
  output logic                 busy,
  output logic                 cfg_err
);
  localparam logic [CNT_W:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  state_t                      state_q;
  logic [CNT_W-1:0]            hp_q;
  logic [CNT_W:0]              cnt_q, cnt_d, per, per_in;
  logic [NPH-1:0][CNT_W-1:0]   off_q, off_d;
  logic [NPH-1:0][CNT_W:0]     pos;
  logic [NPH-1:0]              started_q, hit, run_ph, bad_off, ph_q;
  logic                        sync_q, err_q;
  always_comb begin
    per    = {hp_q, 1'b0};
    per_in = {half_period, 1'b0};
    cnt_d  = (cnt_q == per - ONE) ? '0 : cnt_q + ONE;
    for (int i = 0; i < NPH; i++) begin
      bad_off[i] = {1'b0, phase_off[i*CNT_W +: CNT_W]} >= per_in;
      off_d[i]   = bad_off[i] ? '0 : phase_off[i*CNT_W +: CNT_W];
      hit[i]     = cnt_q == {1'b0, off_q[i]};
      // (cnt - off) mod P; the wrapped sum is exact since the true result is below P
      pos[i]     = (cnt_q >= {1'b0, off_q[i]}) ? cnt_q - {1'b0, off_q[i]}
                                               : cnt_q + per - {1'b0, off_q[i]};
      run_ph[i]  = (started_q[i] | hit[i]) & (pos[i] < {1'b0, hp_q});
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hp_q      <= '0;
      cnt_q     <= '0;
      off_q     <= '0;
      started_q <= '0;
      ph_q      <= '0;
      sync_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (enable) begin
          if (half_period == '0) err_q <= 1'b1;
          else begin
            state_q   <= RUN;
            hp_q      <= half_period;
            cnt_q     <= '0;
            off_q     <= off_d;
            started_q <= '0;
            err_q     <= err_q | (|bad_off);
          end
        end
        default: begin
          cnt_q     <= cnt_d;
          started_q <= started_q | hit;
          // once stopping, a phase may only finish the high half it is already in
          ph_q      <= (state_q == RUN && enable) ? run_ph : run_ph & ph_q;
          sync_q    <= state_q == RUN && enable && cnt_q == '0;
          if (state_q == RUN && !enable) state_q <= STOP;
          else if (state_q != RUN && ph_q == '0) state_q <= IDLE;
        end
      endcase
    end
  end
  assign ph      = ph_q;
  assign sync    = sync_q;
  assign busy    = state_q != IDLE;
  assign cfg_err = err_q;
endmodule

// File: tb/tb_ccd_phase_gen.sv
// tb_ccd_phase_gen: directed checks of phase timing, stop gating, config errors and reset.
module tb_ccd_phase_gen;
  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [15:0] half_period = '0;
  logic [63:0] phase_off = '0;
  logic [3:0]  ph;
  logic        sync, busy, cfg_err;
  int          checks = 0, errors = 0;
  logic [3:0]  t1 [17] = '{4'h1, 4'h1, 4'h3, 4'h3, 4'h6, 4'h6, 4'hC, 4'hC, 4'h9,
                           4'h9, 4'h3, 4'h3, 4'h6, 4'h6, 4'hC, 4'hC, 4'h9};
  logic [16:0] s1 = 17'h10101;
  logic [3:0]  t4 [7] = '{4'h3, 4'h7, 4'h7, 4'h4, 4'h0, 4'h8, 4'hB};
  logic [3:0]  t6 [8] = '{4'h1, 4'h3, 4'h6, 4'hC, 4'h9, 4'h3, 4'h6, 4'hC};
  logic [7:0]  s6 = 8'h11;

  ccd_phase_gen #(.NPH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .half_period(half_period),
    .phase_off(phase_off), .ph(ph), .sync(sync), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input string tag);
    enable = 1'b1;
    tick;
    chk({tag, "_E_busy"}, 32'(busy), 32'd1);
    chk({tag, "_E_ph"}, 32'(ph), 32'd0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    enable = 1'b0;
    while (busy && n < 40) begin
      tick;
      n++;
    end
    chk({tag, "_drain_busy"}, 32'(busy), 32'd0);
    chk({tag, "_drain_ph"}, 32'(ph), 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_ph", 32'(ph), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sync", 32'(sync), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    #12 rst_n = 1'b1;
    tick;
    // basic four-phase run: P=8, offsets 0/2/4/6
    half_period = 16'd4;
    phase_off   = {16'd6, 16'd4, 16'd2, 16'd0};
    start("s1");
    for (int k = 0; k < 17; k++) begin
      tick;
      chk($sformatf("s1_ph_k%0d", k), 32'(ph), 32'(t1[k]));
      chk($sformatf("s1_sync_k%0d", k), 32'(sync), 32'(s1[k]));
    end
    drain("s1");
    chk("s1_err", 32'(cfg_err), 32'd0);
    // stop mid-run, then toggle enable during STOP with a new config presented
    start("s6");
    for (int k = 0; k < 11; k++) begin
      tick;
      chk($sformatf("s6_ph_k%0d", k), 32'(ph), 32'(t1[k]));
    end
    enable = 1'b0;
    tick;
    chk("s2_D_ph", 32'(ph), 32'h3);
    chk("s2_D_sync", 32'(sync), 32'd0);
    chk("s2_D_busy", 32'(busy), 32'd1);
    enable      = 1'b1;
    half_period = 16'd2;
    phase_off   = {16'd3, 16'd2, 16'd1, 16'd0};
    tick;
    chk("s2_E13_ph", 32'(ph), 32'h2);
    enable = 1'b0;
    tick;
    chk("s2_E14_ph", 32'(ph), 32'h2);
    enable = 1'b1;
    tick;
    chk("s2_E15_ph", 32'(ph), 32'h0);
    chk("s2_E15_busy", 32'(busy), 32'd1);
    tick;
    chk("s2_E16_busy", 32'(busy), 32'd0);
    chk("s2_E16_ph", 32'(ph), 32'h0);
    tick;
    chk("s6_E_busy", 32'(busy), 32'd1);
    chk("s6_E_ph", 32'(ph), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick;
      chk($sformatf("s6r_ph_k%0d", k), 32'(ph), 32'(t6[k]));
      chk($sformatf("s6r_sync_k%0d", k), 32'(sync), 32'(s6[k]));
    end
    drain("s6");
    // zero half-period is rejected and flagged
    half_period = 16'd0;
    enable      = 1'b1;
    tick;
    tick;
    tick;
    chk("s3_busy", 32'(busy), 32'd0);
    chk("s3_ph", 32'(ph), 32'd0);
    chk("s3_err", 32'(cfg_err), 32'd1);
    enable = 1'b0;
    tick;
    chk("s3_err_sticky", 32'(cfg_err), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("s3_err_rst", 32'(cfg_err), 32'd0);
    #1 rst_n = 1'b1;
    tick;
    // out-of-range offset on phase 1 is latched as zero
    half_period = 16'd3;
    phase_off   = {16'd5, 16'd1, 16'd9, 16'd0};
    start("s4");
    chk("s4_err", 32'(cfg_err), 32'd1);
    for (int k = 0; k < 7; k++) begin
      tick;
      chk($sformatf("s4_ph_k%0d", k), 32'(ph), 32'(t4[k]));
    end
    drain("s4");
    // asynchronous reset mid-run, then restart on release
    half_period = 16'd4;
    phase_off   = {16'd4, 16'd0, 16'd4, 16'd0};
    start("s5");
    tick;
    chk("s5_pre_ph", 32'(ph), 32'h5);
    chk("s5_pre_sync", 32'(sync), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_rst_ph", 32'(ph), 32'd0);
    chk("s5_rst_busy", 32'(busy), 32'd0);
    chk("s5_rst_sync", 32'(sync), 32'd0);
    chk("s5_rst_err", 32'(cfg_err), 32'd0);
    phase_off = {16'd6, 16'd4, 16'd2, 16'd0};
    #1 rst_n = 1'b1;
    start("s5r");
    for (int k = 0; k < 8; k++) begin
      tick;
      chk($sformatf("s5r_ph_k%0d", k), 32'(ph), 32'(t1[k]));
    end
    drain("s5r");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
